iq_amplitude_source: RTL and testbench
======================================

// Module: iq_amplitude_source
// PURPOSE
//  Producer side of the amplitude/load_val sample interface consumed by the averager.
//  Takes signed I/Q baseband samples and estimates magnitude via alpha-max-beta-min.
//  Decimates by a runtime window length; emits one amplitude word per window with a 1-cycle load_val strobe.
//  Sits between the IQ demod output and the averager core.
// PARAMETERS
//  IN_W    16  width of signed i_data/q_data
//  OUT_W   32  width of amplitude (magnitude zero-extended)
//  DEC_W   16  width of decim control input
// PORTS
//  clk       in   1       single system clock, all logic rising-edge
//  rst       in   1       asynchronous, active-low reset (0 = reset)
//  i_data    in   IN_W    signed in-phase sample
//  q_data    in   IN_W    signed quadrature sample
//  iq_valid  in   1       i_data/q_data valid this cycle; may be high every cycle
//  decim     in   DEC_W   samples per output window; 0 treated as 1
//  amplitude out  OUT_W   window result, held between strobes
//  load_val  out  1       1-cycle strobe: amplitude updated this cycle
//  win_cnt   out  DEC_W   magnitudes accepted in current window (0..decim-1)
// BEHAVIOUR
//  Reset (rst=0, async): amplitude=0, load_val=0, win_cnt=0, all pipeline valids cleared; no strobe after release until a full window completes.
//  S1 abs: |x|; -2^(IN_W-1) saturates to 2^(IN_W-1)-1.
//  S2 sort: mx=max(|I|,|Q|), mn=min(|I|,|Q|).
//  S3 mag = mx - (mx>>4) + (mn>>1) - (mn>>5)  (alpha=15/16, beta=15/32), IN_W+1 bits, never overflows.
//  Pipeline latency 3 cycles iq_valid -> mag_valid; no stalls, no backpressure.
//  Window: decim latched into dec_q when mag_valid arrives with win_cnt==0; mid-window decim changes apply next window.
//  Each mag_valid: win_cnt++; when win_cnt==dec_q-1 -> win_cnt=0, window complete.
//  Cycle after completing mag_valid: amplitude<=result (zero-extended), load_val=1 for exactly 1 cycle.
//  Total latency final iq_valid -> load_val: 4 cycles.
//  dec_q==1 with iq_valid every cycle: load_val high on consecutive cycles; legal.
//  Reset mid-window discards partial window and in-flight pipeline samples.
// CONFIGURATION
//  IQ_PEAK_HOLD_EN defined: result = max mag over the window (peak register seeded by first mag of window).
//  IQ_PEAK_HOLD_EN undefined: result = last mag of the window (plain decimation); no peak register.
// STRUCTURE
//  Package iq_amp_pkg: IN_W/OUT_W/DEC_W defaults, ALPHA_SH=4, BETA_SH1=1, BETA_SH2=5, mag width localparam.
//  Sub-module iq_mag_est: S1..S3 pipeline (i_data,q_data,iq_valid -> mag,mag_valid).
//  Top: window counter, decim latch, optional peak register, output register/strobe.
// TESTING
//  T1 decim=1, I=1080,Q=0 single iq_valid -> amplitude=1013, load_val 1 cycle, 4 cycles later.
//  T2 decim=1, I=Q=-32768 -> abs saturates to 32767 -> amplitude=46080.
//  T3 decim=4, I=Q=1900 x4 -> exactly one strobe, amplitude=2673; win_cnt 1,2,3,0.
//  T4 decim=4, mags from I=(1900,1080,3000,500),Q=0 -> without macro amplitude=469 (500-31); with IQ_PEAK_HOLD_EN 2813.
//  T5 decim=0, iq_valid every cycle -> load_val every cycle after 4-cycle fill; change decim 4->2 mid-window -> current window still 4.
//  T6 rst low after 2 of 4 samples -> outputs 0 immediately; release, 4 new samples -> one strobe, no stale data.

Source files
------------

// File: rtl/iq_amp_pkg.sv
// Shared constants for the IQ amplitude source.
// Default widths and the alpha-max-beta-min shift amounts.
package iq_amp_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 32;
    localparam int DEF_DEC_W = 16;
    localparam int DEF_MAG_W = DEF_IN_W + 1;

    // alpha = 1 - 2^-4, beta = 2^-1 - 2^-5
    localparam int ALPHA_SH = 4;
    localparam int BETA_SH1 = 1;
    localparam int BETA_SH2 = 5;

endpackage

// File: rtl/iq_mag_est.sv
// Three-stage magnitude estimator: abs, sort, alpha-max-beta-min.
// Ports: clk, rst (async, active-low), i_data/q_data/iq_valid in,
//        mag/mag_valid out, 3 cycles after the input sample.
module iq_mag_est
    import iq_amp_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int MAG_W = IN_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] i_data,
    input  logic signed [IN_W-1:0] q_data,
    input  logic                   iq_valid,
    output logic [MAG_W-1:0]       mag,
    output logic                   mag_valid
);

    // The most negative code has no positive twin; clamp it.
    function automatic logic [IN_W-1:0] sat_abs(
        input logic signed [IN_W-1:0] x
    );
        logic [IN_W-1:0] r;
        if (x == {1'b1, {(IN_W-1){1'b0}}})
            r = {1'b0, {(IN_W-1){1'b1}}};
        else if (x[IN_W-1])
            r = -x;
        else
            r = x;
        return r;
    endfunction

    logic            v1_q, v2_q, v3_q;
    logic [IN_W-1:0] ai_q, aq_q, ai_d, aq_d;
    logic [IN_W-1:0] mx_q, mn_q, mx_d, mn_d;
    logic [MAG_W-1:0] mag_q, mag_d;

    always_comb begin
        ai_d = sat_abs(i_data);
        aq_d = sat_abs(q_data);
        mx_d = (ai_q >= aq_q) ? ai_q : aq_q;
        mn_d = (ai_q >= aq_q) ? aq_q : ai_q;
        mag_d = MAG_W'(mx_q)
              - MAG_W'(mx_q >> ALPHA_SH)
              + MAG_W'(mn_q >> BETA_SH1)
              - MAG_W'(mn_q >> BETA_SH2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            ai_q  <= '0;
            aq_q  <= '0;
            mx_q  <= '0;
            mn_q  <= '0;
            mag_q <= '0;
        end else begin
            v1_q  <= iq_valid;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            ai_q  <= ai_d;
            aq_q  <= aq_d;
            mx_q  <= mx_d;
            mn_q  <= mn_d;
            mag_q <= mag_d;
        end
    end

    assign mag       = mag_q;
    assign mag_valid = v3_q;

endmodule

// File: rtl/iq_amplitude_source.sv
// IQ amplitude source: magnitude estimate decimated per window.
// Ports: clk, rst (async, active-low), i_data, q_data, iq_valid, decim in;
//        amplitude, load_val (1-cycle strobe), win_cnt out.
// Build option IQ_PEAK_HOLD_EN: report the window peak, not the last mag.
module iq_amplitude_source
    import iq_amp_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DEC_W = DEF_DEC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] i_data,
    input  logic signed [IN_W-1:0] q_data,
    input  logic                   iq_valid,
    input  logic [DEC_W-1:0]       decim,
    output logic [OUT_W-1:0]       amplitude,
    output logic                   load_val,
    output logic [DEC_W-1:0]       win_cnt
);

    localparam int MAG_W = IN_W + 1;

    logic [MAG_W-1:0] mag;
    logic             mag_valid;

    iq_mag_est #(
        .IN_W  (IN_W),
        .MAG_W (MAG_W)
    ) u_mag (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .q_data    (q_data),
        .iq_valid  (iq_valid),
        .mag       (mag),
        .mag_valid (mag_valid)
    );

    logic [DEC_W-1:0] win_cnt_q, win_cnt_d;
    logic [DEC_W-1:0] dec_q, dec_d;
    logic [OUT_W-1:0] amp_q, amp_d;
    logic             load_q, load_d;
    logic [DEC_W-1:0] dec_in, dec_eff;
    logic             first, last;
    logic [MAG_W-1:0] win_mag;
`ifdef IQ_PEAK_HOLD_EN
    logic [MAG_W-1:0] peak_q, peak_d;
`endif

    always_comb begin
        dec_in    = (decim == '0) ? DEC_W'(1) : decim;
        first     = (win_cnt_q == '0);
        // The first mag of a window sees the live decim, later ones dec_q.
        dec_eff   = first ? dec_in : dec_q;
        last      = (win_cnt_q == dec_eff - DEC_W'(1));
        win_cnt_d = win_cnt_q;
        dec_d     = dec_q;
        amp_d     = amp_q;
        load_d    = 1'b0;
`ifdef IQ_PEAK_HOLD_EN
        win_mag   = (first || mag > peak_q) ? mag : peak_q;
        peak_d    = peak_q;
`else
        win_mag   = mag;
`endif
        if (mag_valid) begin
            if (first)
                dec_d = dec_in;
            win_cnt_d = last ? '0 : win_cnt_q + DEC_W'(1);
`ifdef IQ_PEAK_HOLD_EN
            peak_d = win_mag;
`endif
            if (last) begin
                amp_d  = OUT_W'(win_mag);
                load_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt_q <= '0;
            dec_q     <= '0;
            amp_q     <= '0;
            load_q    <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            dec_q     <= dec_d;
            amp_q     <= amp_d;
            load_q    <= load_d;
        end
    end

`ifdef IQ_PEAK_HOLD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            peak_q <= '0;
        else
            peak_q <= peak_d;
    end
`endif

    assign amplitude = amp_q;
    assign load_val  = load_q;
    assign win_cnt   = win_cnt_q;

endmodule

// File: tb/tb_iq_amplitude_source.sv
// Directed bench for iq_amplitude_source.
// Table of single-sample windows plus multi-cycle window/reset sequences.
module tb_iq_amplitude_source;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] i_data;
    logic signed [15:0] q_data;
    logic               iq_valid;
    logic [15:0]        decim;
    logic [31:0]        amplitude;
    logic               load_val;
    logic [15:0]        win_cnt;

    always #5 clk = ~clk;

    iq_amplitude_source dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .q_data    (q_data),
        .iq_valid  (iq_valid),
        .decim     (decim),
        .amplitude (amplitude),
        .load_val  (load_val),
        .win_cnt   (win_cnt)
    );

    typedef struct {
        logic [15:0]        dec;
        logic signed [15:0] i;
        logic signed [15:0] q;
        int                 amp;
    } vec_t;

    vec_t               vecs [9];
    logic signed [15:0] win_i [4];
    int                 n_chk = 0;
    int                 n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One valid sample, decim 1 (or 0): strobe 4 cycles later, once.
    task automatic run_single(input int idx);
        int lat;
        int ns;
        int amp;
        lat = 0;
        ns = 0;
        amp = -1;
        decim = vecs[idx].dec;
        i_data = vecs[idx].i;
        q_data = vecs[idx].q;
        iq_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) iq_valid = 1'b0;
            if (load_val) begin
                ns++;
                if (lat == 0) begin
                    lat = c;
                    amp = int'(amplitude);
                end
            end
        end
        chk($sformatf("v%0d_lat", idx), lat, 4);
        chk($sformatf("v%0d_nstrobe", idx), ns, 1);
        chk($sformatf("v%0d_amp", idx), amp, vecs[idx].amp);
    endtask

    // Four back-to-back samples from win_i with Q=q, decim 4.
    task automatic run_win4(input string tag,
                            input logic signed [15:0] q,
                            input int exp_amp);
        int ns;
        int amp;
        ns = 0;
        amp = -1;
        decim = 16'd4;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                i_data = win_i[c];
                q_data = q;
                iq_valid = 1'b1;
            end else begin
                iq_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 3 && c <= 6)
                chk($sformatf("%s_wcnt%0d", tag, c + 1),
                    int'(win_cnt), (c - 2) % 4);
            if (load_val) begin
                ns++;
                amp = int'(amplitude);
            end
        end
        chk({tag, "_nstrobe"}, ns, 1);
        chk({tag, "_amp"}, amp, exp_amp);
    endtask

    initial begin
        vecs[0] = '{16'd1, 16'sd1080, 16'sd0, 1013};
        vecs[1] = '{16'd1, 16'h8000, 16'h8000, 46080};
        vecs[2] = '{16'd0, 16'sd0, 16'sd0, 0};
        vecs[3] = '{16'd1, -16'sd1080, 16'sd0, 1013};
        vecs[4] = '{16'd0, 16'sd0, 16'sd1080, 1013};
        vecs[5] = '{16'd1, 16'sd1900, 16'sd1900, 2673};
        vecs[6] = '{16'd1, 16'h8000, 16'sd0, 30720};
        vecs[7] = '{16'd1, 16'sd100, -16'sd200, 235};
        vecs[8] = '{16'd1, 16'sd32767, -16'sd32767, 46080};

        rst = 1'b0;
        i_data = '0;
        q_data = '0;
        iq_valid = 1'b0;
        decim = 16'd1;
        repeat (2) @(negedge clk);
        chk("rst_amp", int'(amplitude), 0);
        chk("rst_load", int'(load_val), 0);
        chk("rst_wcnt", int'(win_cnt), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 9; v++)
            run_single(v);

        // T3: equal samples, one strobe per 4.
        for (int k = 0; k < 4; k++) win_i[k] = 16'sd1900;
        run_win4("t3", 16'sd1900, 2673);

        // T4: last mag vs peak mag of the window.
        win_i[0] = 16'sd1900;
        win_i[1] = 16'sd1080;
        win_i[2] = 16'sd3000;
        win_i[3] = 16'sd500;
`ifdef IQ_PEAK_HOLD_EN
        run_win4("t4", 16'sd0, 2813);
`else
        run_win4("t4", 16'sd0, 469);
`endif

        // T5a: decim 0 with continuous input strobes every cycle.
        decim = 16'd0;
        for (int c = 0; c < 10; c++) begin
            iq_valid = (c < 8);
            i_data = 16'sd1080;
            q_data = 16'sd0;
            @(negedge clk);
            chk($sformatf("t5a_load%0d", c + 1),
                int'(load_val), (c + 1 >= 4) ? 1 : 0);
        end
        repeat (4) @(negedge clk);
        chk("t5a_wcnt", int'(win_cnt), 0);

        // T5b: decim 4 -> 2 after the window latched it.
        decim = 16'd4;
        for (int c = 0; c < 13; c++) begin
            if (c == 5) decim = 16'd2;
            iq_valid = (c < 8);
            @(negedge clk);
            if (c + 1 >= 4)
                chk($sformatf("t5b_load%0d", c + 1), int'(load_val),
                    (c + 1 == 7 || c + 1 == 9 || c + 1 == 11) ? 1 : 0);
            if (c + 1 == 7)
                chk("t5b_amp", int'(amplitude), 1013);
        end

        // T6: reset with one mag counted and one in flight.
        decim = 16'd4;
        for (int c = 0; c < 4; c++) begin
            iq_valid = (c < 2);
            i_data = 16'sd1900;
            q_data = 16'sd0;
            @(negedge clk);
        end
        chk("t6_pre_wcnt", int'(win_cnt), 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_amp", int'(amplitude), 0);
        chk("t6_rst_load", int'(load_val), 0);
        chk("t6_rst_wcnt", int'(win_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        begin
            int stale;
            stale = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (load_val || win_cnt != 16'd0) stale++;
            end
            chk("t6_no_stale", stale, 0);
        end
        for (int k = 0; k < 4; k++) win_i[k] = 16'sd500;
        run_win4("t6", 16'sd0, 469);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
